// File: rtl/i2c_target.sv
// I2C target with one fixed 7-bit address. SCL/SDA are oversampled on clk.
// Writes come out as a byte stream; reads are served from a 1-byte ready/valid holding register.
module i2c_target #(
  parameter logic [6:0] ADDRESS     = 7'h10,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_first,
  output logic       i_ready,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_underflow,
  output logic       o_busy
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_ADDR, S_RX, S_ACK_RX, S_TX, S_ACK_TX, S_IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d, sda_oe, rw, rx_first, tx_ack, full;
  logic [3:0]             bit_cnt;
  logic [7:0]             sr, tx_sr, hold, tx_byte;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start, stop;

  assign sda      = sda_oe ? 1'b0 : 1'bz;
  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;
  assign tx_byte  = full ? hold : 8'hFF;
  assign i_ready  = ~full & ((state == S_TX) | (state == S_ACK_TX) |
                             ((state == S_ACK_ADDR) & rw));

  // Synchronizers reset to the idle-bus level so reset release never looks like a START.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      sda_oe      <= 1'b0;
      o_valid     <= 1'b0;
      o_data      <= 8'h00;
      o_first     <= 1'b0;
      o_underflow <= 1'b0;
      o_busy      <= 1'b0;
      rw          <= 1'b0;
      rx_first    <= 1'b0;
      tx_ack      <= 1'b0;
      full        <= 1'b0;
      hold        <= 8'h00;
      bit_cnt     <= 4'd0;
      sr          <= 8'h00;
      tx_sr       <= 8'h00;
    end else begin
      o_valid     <= 1'b0;
      o_underflow <= 1'b0;
      if (i_valid && i_ready) begin
        hold <= i_data;
        full <= 1'b1;
      end
      if (start) begin
        state   <= S_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        full    <= 1'b0;
      end else if (stop) begin
        state   <= S_IDLE;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        o_busy  <= 1'b0;
        full    <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise) begin
              sr      <= {sr[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (sr[7:1] == ADDRESS) begin
                state  <= S_ACK_ADDR;
                sda_oe <= 1'b1;
                o_busy <= 1'b1;
                rw     <= sr[0];
              end else begin
                state  <= S_IGNORE;
                o_busy <= 1'b0;
              end
            end
          end
          S_RX: begin
            if (scl_rise) begin
              sr      <= {sr[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                o_data   <= {sr[6:0], sda_s};
                o_valid  <= 1'b1;
                o_first  <= rx_first;
                rx_first <= 1'b0;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state  <= S_ACK_RX;
              sda_oe <= 1'b1;
            end
          end
          S_ACK_RX: begin
            if (scl_fall) begin
              state   <= S_RX;
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
            end
          end
          S_TX: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state  <= S_ACK_TX;
                sda_oe <= 1'b0;
                tx_ack <= 1'b0;
              end else begin
                sda_oe  <= ~tx_sr[7];
                tx_sr   <= {tx_sr[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          S_ACK_ADDR, S_ACK_TX: begin
            if (state == S_ACK_TX && scl_rise) begin
              if (sda_s) state <= S_IGNORE;
              else       tx_ack <= 1'b1;
            end else if (scl_fall) begin
              if (state == S_ACK_ADDR && !rw) begin
                state    <= S_RX;
                sda_oe   <= 1'b0;
                bit_cnt  <= 4'd0;
                rx_first <= 1'b1;
              end else if (state == S_ACK_ADDR || tx_ack) begin
                // Byte load: MSB goes on the bus in this same fall.
                state   <= S_TX;
                sda_oe  <= ~tx_byte[7];
                tx_sr   <= {tx_byte[6:0], 1'b0};
                bit_cnt <= 4'd1;
                if (full) full <= 1'b0;
                else      o_underflow <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// Bench acting as I2C controller and read-data source, with a transaction-level
// model of expected ACKs, write bytes, read bytes, underflows and handshakes.
module tb_i2c_target;
  localparam int Q = 6;

  logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, ctl_low = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = 8'h00;
  wire        sda;
  logic       o_valid, o_first, i_ready, o_underflow, o_busy;
  logic [7:0] o_data;

  assign sda = ctl_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_target #(.ADDRESS(7'h10), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .o_valid(o_valid), .o_data(o_data), .o_first(o_first),
    .i_ready(i_ready), .i_valid(i_valid), .i_data(i_data),
    .o_underflow(o_underflow), .o_busy(o_busy));

  always #5 clk = ~clk;

  int         total = 0, bad = 0;
  logic [7:0] exp_q[$];
  logic       exp_first_q[$];
  logic [7:0] got_log[$];
  logic [7:0] src_q[$];
  logic [7:0] buf_b[8];
  int         uf_seen = 0, hs_cnt = 0, tgt_low = 0;
  logic       hs_flag = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: every o_valid must match the next expected write byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) begin
        chk("valid_with_underflow", o_underflow, 0);
        chk("o_valid_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("o_data", o_data, exp_q.pop_front());
          chk("o_first", o_first, exp_first_q.pop_front());
        end
        got_log.push_back(o_data);
      end
      if (o_underflow) uf_seen++;
      if (!ctl_low && sda === 1'b0) tgt_low++;
    end
  end

  // Read source: i_valid whenever the source queue has data.
  always @(negedge clk) begin
    if (hs_flag) begin
      void'(src_q.pop_front());
      hs_cnt++;
    end
    i_valid = (src_q.size() > 0);
    i_data  = i_valid ? src_q[0] : 8'h00;
    hs_flag = i_valid && i_ready && !rst;
  end

  task automatic qw();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic drv, output logic rd);
    ctl_low = ~drv; qw();
    scl = 1'b1; qw();
    rd = sda; qw();
    scl = 1'b0; qw();
  endtask

  task automatic byte_xfer(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic start_c();
    ctl_low = 1'b0; qw();
    scl = 1'b1; qw();
    ctl_low = 1'b1; qw();
    scl = 1'b0; qw();
  endtask

  task automatic stop_c();
    ctl_low = 1'b1; qw();
    scl = 1'b1; qw();
    ctl_low = 1'b0; qw(); qw();
  endtask

  task automatic do_write(input logic [6:0] a, input int n);
    logic       match, ack;
    logic [7:0] r;
    int         t0;
    match = (a == 7'h10);
    t0 = tgt_low;
    start_c();
    byte_xfer({a, 1'b0}, r);
    bit_xfer(1'b1, ack);
    chk("wr_addr_ack", ack, !match);
    chk("wr_busy", o_busy, match);
    for (int k = 0; k < n; k++) begin
      if (match) begin
        exp_q.push_back(buf_b[k]);
        exp_first_q.push_back(k == 0);
      end
      byte_xfer(buf_b[k], r);
      bit_xfer(1'b1, ack);
      chk("wr_data_ack", ack, !match);
    end
    stop_c();
    chk("wr_busy_after_stop", o_busy, 0);
    chk("wr_all_bytes_seen", exp_q.size(), 0);
    if (!match) chk("wr_no_drive", tgt_low - t0, 0);
  endtask

  task automatic do_read(input logic [6:0] a, input int n, input int m);
    logic       match, ack;
    logic [7:0] r;
    int         uf0, hs0;
    match = (a == 7'h10);
    uf0 = uf_seen;
    hs0 = hs_cnt;
    if (match) for (int k = 0; k < m; k++) src_q.push_back(buf_b[k]);
    start_c();
    byte_xfer({a, 1'b1}, r);
    bit_xfer(1'b1, ack);
    chk("rd_addr_ack", ack, !match);
    if (match) begin
      for (int k = 0; k < n; k++) begin
        byte_xfer(8'hFF, r);
        chk("rd_byte", r, (k < m) ? buf_b[k] : 8'hFF);
        bit_xfer(k == n - 1, ack);
      end
      // After NACK the target must stay off the bus.
      byte_xfer(8'hFF, r);
      chk("rd_ignore_after_nack", r, 8'hFF);
    end
    stop_c();
    chk("rd_underflows", uf_seen - uf0, match ? n - m : 0);
    chk("rd_handshakes", hs_cnt - hs0, match ? m : 0);
    chk("rd_busy_after_stop", o_busy, 0);
    src_q.delete();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic       ack;
    int         nlog;
    repeat (5) @(negedge clk);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_busy", o_busy, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_sda", sda, 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Write 0xA5, 0x3C to our address.
    buf_b[0] = 8'hA5; buf_b[1] = 8'h3C;
    nlog = got_log.size();
    do_write(7'h10, 2);
    chk("wr_log_count", got_log.size() - nlog, 2);
    chk("wr_log_0", got_log[nlog], 8'hA5);
    chk("wr_log_1", got_log[nlog+1], 8'h3C);

    // Other address: no ACK, no drive, no data.
    nlog = got_log.size();
    do_write(7'h11, 2);
    chk("wr_other_no_valid", got_log.size() - nlog, 0);

    // Read 0x5A, 0xC3 then NACK.
    buf_b[0] = 8'h5A; buf_b[1] = 8'hC3;
    do_read(7'h10, 2, 2);

    // Read with no source data: one 0xFF byte, one underflow.
    do_read(7'h10, 1, 0);

    // Repeated START mid-byte, then STOP mid-byte.
    nlog = got_log.size();
    start_c();
    byte_xfer({7'h10, 1'b0}, r);
    bit_xfer(1'b1, ack);
    chk("rs_first_ack", ack, 0);
    for (int i = 0; i < 4; i++) bit_xfer(i[0], ack);
    start_c();
    byte_xfer({7'h10, 1'b0}, r);
    bit_xfer(1'b1, ack);
    chk("rs_second_ack", ack, 0);
    for (int i = 0; i < 3; i++) bit_xfer(1'b0, ack);
    stop_c();
    chk("rs_no_valid", got_log.size() - nlog, 0);
    chk("rs_busy", o_busy, 0);
    chk("rs_sda_released", sda, 1);

    // Reset while target is ACKing a write byte.
    start_c();
    byte_xfer({7'h10, 1'b0}, r);
    bit_xfer(1'b1, ack);
    exp_q.push_back(8'h77);
    exp_first_q.push_back(1'b1);
    byte_xfer(8'h77, r);
    ctl_low = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack_driven", sda, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_sda", sda, 1);
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_o_data", o_data, 0);
    chk("rst_mid_o_first", o_first, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    buf_b[0] = 8'h81;
    do_write(7'h10, 1);

    // Randomized transactions.
    for (int t = 0; t < 12; t++) begin
      logic [6:0] a;
      int         n, m;
      a = ($urandom_range(0, 9) < 7) ? 7'h10 : 7'($urandom_range(0, 127));
      if (a != 7'h10 && a[0] == 1'b0 && a == 7'h10) a = 7'h11;
      n = $urandom_range(1, 3);
      m = $urandom_range(0, n);
      for (int k = 0; k < 8; k++) buf_b[k] = 8'($urandom);
      if ($urandom_range(0, 1) == 0) do_write(a, n);
      else                           do_read(a, n, m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
